// File: rtl/ysyx_25040129_lsu_pkg.sv
// Shared LSU definitions: register index width, load/store encodings,
// FSM state encoding and the alignment helper used by the optional
// misalignment check (YSYX_25040129_LSU_MISALIGN_CHECK_EN).
package ysyx_25040129_lsu_pkg;

    localparam int REGS_DIG = 5;

    localparam logic [2:0] NO_MEM_READ = 3'd0;
    localparam logic [2:0] LSU_LB      = 3'd1;
    localparam logic [2:0] LSU_LH      = 3'd2;
    localparam logic [2:0] LSU_LW      = 3'd3;
    localparam logic [2:0] LSU_LBU     = 3'd4;
    localparam logic [2:0] LSU_LHU     = 3'd5;

    localparam logic [1:0] NO_MEM_WRITE = 2'd0;
    localparam logic [1:0] LSU_SB       = 2'd1;
    localparam logic [1:0] LSU_SH       = 2'd2;
    localparam logic [1:0] LSU_SW       = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    // Halfword accesses need addr[0]=0, word accesses need addr[1:0]=0.
    function automatic logic is_misaligned(input logic [2:0] rd_type,
                                           input logic [1:0] wr_type,
                                           input logic [1:0] off);
        logic half;
        logic word;
        half = (rd_type == LSU_LH) || (rd_type == LSU_LHU) || (wr_type == LSU_SH);
        word = (rd_type == LSU_LW) || (wr_type == LSU_SW);
        return (half && off[0]) || (word && (off != 2'b00));
    endfunction

endpackage

// File: rtl/ysyx_25040129_lsu_align.sv
// Combinational lane logic: store byte/halfword replication plus write mask,
// and load lane selection with sign or zero extension.
module ysyx_25040129_lsu_align
    import ysyx_25040129_lsu_pkg::*;
(
    input  logic [1:0]  st_type,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wmask,
    input  logic [2:0]  ld_type,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [31:0] ld_shifted;

    // Store data replicated across the word so the mask alone picks the lane.
    always_comb begin
        st_wdata = 32'h0;
        st_wmask = 4'b0000;
        case (st_type)
            LSU_SB: begin
                st_wdata = {4{st_data[7:0]}};
                st_wmask = 4'b0001 << st_off;
            end
            LSU_SH: begin
                st_wdata = {2{st_data[15:0]}};
                st_wmask = 4'b0011 << st_off;
            end
            LSU_SW: begin
                st_wdata = st_data;
                st_wmask = 4'b1111;
            end
            default: ;
        endcase
    end

    // Load lane moved down to bit 0, then extended according to the load type.
    always_comb begin
        ld_shifted = ld_rdata >> {ld_off, 3'b000};
        ld_data    = 32'h0;
        case (ld_type)
            LSU_LB:  ld_data = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            LSU_LBU: ld_data = {24'h0, ld_shifted[7:0]};
            LSU_LH:  ld_data = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            LSU_LHU: ld_data = {16'h0, ld_shifted[15:0]};
            LSU_LW:  ld_data = ld_rdata;
            default: ld_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/ysyx_25040129_lsu.sv
// Load/store unit: EXU handshake in, one memory request/response per
// transaction, WBU handshake out. Optional misalignment trap is enabled
// by defining YSYX_25040129_LSU_MISALIGN_CHECK_EN.
module ysyx_25040129_lsu
    import ysyx_25040129_lsu_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                is_req_valid_from_exu,
    output logic                is_req_ready_to_exu,
    input  logic [31:0]         result_in_lsu,
    input  logic [31:0]         lsu_write_data_in_lsu,
    input  logic [2:0]          lsu_read_in_lsu,
    input  logic [1:0]          lsu_write_in_lsu,
    input  logic [REGS_DIG-1:0] rd_in_lsu,
    input  logic                reg_write_in_lsu,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [31:0]         mem_addr,
    output logic                mem_wen,
    output logic [31:0]         mem_wdata,
    output logic [3:0]          mem_wmask,
    input  logic                mem_resp_valid,
    output logic                mem_resp_ready,
    input  logic [31:0]         mem_rdata,
    input  logic                mem_resp_err,
    output logic                is_req_valid_to_wbu,
    input  logic                is_req_ready_from_wbu,
    output logic [31:0]         wb_data_out_lsu,
    output logic [REGS_DIG-1:0] rd_out_lsu,
    output logic                reg_write_out_lsu,
    output logic                lsu_fault_out,
    output logic                is_data_forward_valid_from_lsu
);

    lsu_state_e  state;
    logic [2:0]  read_q;
    logic [1:0]  off_q;
    logic        latched_q;
    logic [31:0] st_wdata;
    logic [3:0]  st_wmask;
    logic [31:0] ld_data;

    ysyx_25040129_lsu_align u_align (
        .st_type  (lsu_write_in_lsu),
        .st_off   (result_in_lsu[1:0]),
        .st_data  (lsu_write_data_in_lsu),
        .st_wdata (st_wdata),
        .st_wmask (st_wmask),
        .ld_type  (read_q),
        .ld_off   (off_q),
        .ld_rdata (mem_rdata),
        .ld_data  (ld_data)
    );

    assign is_req_ready_to_exu = (state == ST_IDLE);
    assign mem_req_valid       = (state == ST_REQ);
    assign mem_resp_ready      = (state == ST_RESP);
    assign is_req_valid_to_wbu = (state == ST_DONE);
    // Non-load results are final at accept; load data only once captured.
    assign is_data_forward_valid_from_lsu =
        (state == ST_DONE) || (latched_q && (read_q == NO_MEM_READ));

    // Transaction FSM; every request and writeback field is registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= ST_IDLE;
            read_q            <= NO_MEM_READ;
            off_q             <= 2'b00;
            latched_q         <= 1'b0;
            mem_addr          <= 32'h0;
            mem_wen           <= 1'b0;
            mem_wdata         <= 32'h0;
            mem_wmask         <= 4'b0000;
            wb_data_out_lsu   <= 32'h0;
            rd_out_lsu        <= '0;
            reg_write_out_lsu <= 1'b0;
            lsu_fault_out     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (is_req_valid_from_exu) begin
                        latched_q         <= 1'b1;
                        read_q            <= lsu_read_in_lsu;
                        off_q             <= result_in_lsu[1:0];
                        wb_data_out_lsu   <= result_in_lsu;
                        rd_out_lsu        <= rd_in_lsu;
                        reg_write_out_lsu <= reg_write_in_lsu && (lsu_write_in_lsu == NO_MEM_WRITE);
                        lsu_fault_out     <= 1'b0;
                        mem_addr          <= {result_in_lsu[31:2], 2'b00};
                        mem_wen           <= (lsu_write_in_lsu != NO_MEM_WRITE);
                        mem_wdata         <= st_wdata;
                        mem_wmask         <= st_wmask;
                        if ((lsu_read_in_lsu == NO_MEM_READ) && (lsu_write_in_lsu == NO_MEM_WRITE)) begin
                            state <= ST_DONE;
                        end
`ifdef YSYX_25040129_LSU_MISALIGN_CHECK_EN
                        else if (is_misaligned(lsu_read_in_lsu, lsu_write_in_lsu, result_in_lsu[1:0])) begin
                            lsu_fault_out     <= 1'b1;
                            reg_write_out_lsu <= 1'b0;
                            state             <= ST_DONE;
                        end
`endif
                        else begin
                            state <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) state <= ST_RESP;
                end
                ST_RESP: begin
                    if (mem_resp_valid) begin
                        if (read_q != NO_MEM_READ) wb_data_out_lsu <= ld_data;
                        if (mem_resp_err) begin
                            lsu_fault_out     <= 1'b1;
                            reg_write_out_lsu <= 1'b0;
                        end
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (is_req_ready_from_wbu) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25040129_lsu.sv
// Scoreboard bench for ysyx_25040129_lsu: expected bus requests and
// writeback results are queued at stimulus time and popped when observed.
module tb_ysyx_25040129_lsu;
    import ysyx_25040129_lsu_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                is_req_valid_from_exu = 1'b0;
    logic                is_req_ready_to_exu;
    logic [31:0]         result_in_lsu = '0;
    logic [31:0]         lsu_write_data_in_lsu = '0;
    logic [2:0]          lsu_read_in_lsu = '0;
    logic [1:0]          lsu_write_in_lsu = '0;
    logic [REGS_DIG-1:0] rd_in_lsu = '0;
    logic                reg_write_in_lsu = 1'b0;
    logic                mem_req_valid;
    logic                mem_req_ready = 1'b0;
    logic [31:0]         mem_addr;
    logic                mem_wen;
    logic [31:0]         mem_wdata;
    logic [3:0]          mem_wmask;
    logic                mem_resp_valid = 1'b0;
    logic                mem_resp_ready;
    logic [31:0]         mem_rdata = '0;
    logic                mem_resp_err = 1'b0;
    logic                is_req_valid_to_wbu;
    logic                is_req_ready_from_wbu = 1'b0;
    logic [31:0]         wb_data_out_lsu;
    logic [REGS_DIG-1:0] rd_out_lsu;
    logic                reg_write_out_lsu;
    logic                lsu_fault_out;
    logic                is_data_forward_valid_from_lsu;

    typedef struct packed {
        logic [31:0]         data;
        logic [REGS_DIG-1:0] rd;
        logic                rw;
        logic                fault;
    } wb_exp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } req_exp_t;

    wb_exp_t  wb_q[$];
    req_exp_t req_q[$];
    int errors = 0;
    int checks = 0;

    ysyx_25040129_lsu dut (
        .clk                            (clk),
        .rst_n                          (rst_n),
        .is_req_valid_from_exu          (is_req_valid_from_exu),
        .is_req_ready_to_exu            (is_req_ready_to_exu),
        .result_in_lsu                  (result_in_lsu),
        .lsu_write_data_in_lsu          (lsu_write_data_in_lsu),
        .lsu_read_in_lsu                (lsu_read_in_lsu),
        .lsu_write_in_lsu               (lsu_write_in_lsu),
        .rd_in_lsu                      (rd_in_lsu),
        .reg_write_in_lsu               (reg_write_in_lsu),
        .mem_req_valid                  (mem_req_valid),
        .mem_req_ready                  (mem_req_ready),
        .mem_addr                       (mem_addr),
        .mem_wen                        (mem_wen),
        .mem_wdata                      (mem_wdata),
        .mem_wmask                      (mem_wmask),
        .mem_resp_valid                 (mem_resp_valid),
        .mem_resp_ready                 (mem_resp_ready),
        .mem_rdata                      (mem_rdata),
        .mem_resp_err                   (mem_resp_err),
        .is_req_valid_to_wbu            (is_req_valid_to_wbu),
        .is_req_ready_from_wbu          (is_req_ready_from_wbu),
        .wb_data_out_lsu                (wb_data_out_lsu),
        .rd_out_lsu                     (rd_out_lsu),
        .reg_write_out_lsu              (reg_write_out_lsu),
        .lsu_fault_out                  (lsu_fault_out),
        .is_data_forward_valid_from_lsu (is_data_forward_valid_from_lsu)
    );

    always #5 clk = ~clk;

    // Reference load extraction, written as explicit lane picks.
    function automatic logic [31:0] model_load(input logic [2:0] rt, input logic [1:0] lo,
                                               input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'd0: b = rdata[7:0];
            2'd1: b = rdata[15:8];
            2'd2: b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = lo[1] ? rdata[31:16] : rdata[15:0];
        case (rt)
            LSU_LB:  return {{24{b[7]}}, b};
            LSU_LBU: return {24'h0, b};
            LSU_LH:  return {{16{h[15]}}, h};
            LSU_LHU: return {16'h0, h};
            default: return rdata;
        endcase
    endfunction

    function automatic req_exp_t model_req(input logic [1:0] wt, input logic [31:0] addr,
                                           input logic [31:0] wd);
        req_exp_t r;
        r.addr  = addr & 32'hFFFF_FFFC;
        r.wen   = (wt != NO_MEM_WRITE);
        r.wdata = 32'h0;
        r.wmask = 4'b0000;
        case (wt)
            LSU_SB: begin
                r.wdata = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
                case (addr[1:0])
                    2'd0: r.wmask = 4'b0001;
                    2'd1: r.wmask = 4'b0010;
                    2'd2: r.wmask = 4'b0100;
                    default: r.wmask = 4'b1000;
                endcase
            end
            LSU_SH: begin
                r.wdata = {wd[15:0], wd[15:0]};
                r.wmask = addr[1] ? 4'b1100 : 4'b0011;
            end
            LSU_SW: begin
                r.wdata = wd;
                r.wmask = 4'b1111;
            end
            default: ;
        endcase
        return r;
    endfunction

    // Drives one EXU transaction, services the bus and drains the WBU side,
    // popping the scoreboard as each output appears.
    task automatic run_txn(input logic [2:0] rt, input logic [1:0] wt, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rdata, input logic err,
                           input int req_stall, input int wb_stall, input logic [REGS_DIG-1:0] rd,
                           input logic rw, input logic exp_bus);
        wb_exp_t  e;
        req_exp_t r;
        int       n;
        logic     is_load;
        is_load = (rt != NO_MEM_READ);
        @(negedge clk);
        checks++;
        if (is_req_ready_to_exu !== 1'b1) begin
            errors++;
            $display("FAIL exu_ready_before: got=%b want=1", is_req_ready_to_exu);
        end
        is_req_valid_from_exu = 1'b1;
        result_in_lsu         = addr;
        lsu_write_data_in_lsu = wd;
        lsu_read_in_lsu       = rt;
        lsu_write_in_lsu      = wt;
        rd_in_lsu             = rd;
        reg_write_in_lsu      = rw;
        @(negedge clk);
        is_req_valid_from_exu = 1'b0;
        result_in_lsu         = $urandom;
        lsu_write_data_in_lsu = $urandom;
        if (exp_bus) begin
            n = 0;
            while (mem_req_valid !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            r = req_q.pop_front();
            for (int i = 0; i <= req_stall; i++) begin
                checks++;
                if ({mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask} !==
                    {1'b1, r.addr, r.wen, r.wdata, r.wmask}) begin
                    errors++;
                    $display("FAIL mem_req[%0d]: got v=%b a=%h w=%b d=%h m=%b want v=1 a=%h w=%b d=%h m=%b",
                             i, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
                             r.addr, r.wen, r.wdata, r.wmask);
                end
                checks++;
                if (is_data_forward_valid_from_lsu !== !is_load) begin
                    errors++;
                    $display("FAIL fwd_in_req: got=%b want=%b", is_data_forward_valid_from_lsu, !is_load);
                end
                if (i == req_stall) mem_req_ready = 1'b1;
                @(negedge clk);
            end
            mem_req_ready = 1'b0;
            checks++;
            if ({mem_resp_ready, mem_req_valid} !== 2'b10) begin
                errors++;
                $display("FAIL resp_phase: got resp_ready=%b req_valid=%b want 1,0", mem_resp_ready, mem_req_valid);
            end
            @(negedge clk);
            mem_resp_valid = 1'b1;
            mem_rdata      = rdata;
            mem_resp_err   = err;
            @(negedge clk);
            mem_resp_valid = 1'b0;
            mem_resp_err   = 1'b0;
            mem_rdata      = $urandom;
        end
        n = 0;
        while (is_req_valid_to_wbu !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (is_req_valid_to_wbu !== 1'b1 || (!exp_bus && n != 0)) begin
            errors++;
            $display("FAIL wbu_valid: got=%b after %0d extra cycles want=1 (no-bus latency 1)", is_req_valid_to_wbu, n);
        end
        e = wb_q.pop_front();
        for (int i = 0; i <= wb_stall; i++) begin
            checks++;
            if ({is_req_valid_to_wbu, wb_data_out_lsu, rd_out_lsu, reg_write_out_lsu, lsu_fault_out,
                 is_data_forward_valid_from_lsu, mem_req_valid} !==
                {1'b1, e.data, e.rd, e.rw, e.fault, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL wb_out[%0d]: got v=%b d=%h rd=%0d rw=%b f=%b fwd=%b req=%b want v=1 d=%h rd=%0d rw=%b f=%b fwd=1 req=0",
                         i, is_req_valid_to_wbu, wb_data_out_lsu, rd_out_lsu, reg_write_out_lsu,
                         lsu_fault_out, is_data_forward_valid_from_lsu, mem_req_valid,
                         e.data, e.rd, e.rw, e.fault);
            end
            if (i == wb_stall) is_req_ready_from_wbu = 1'b1;
            @(negedge clk);
        end
        is_req_ready_from_wbu = 1'b0;
        checks++;
        if ({is_req_ready_to_exu, is_req_valid_to_wbu} !== 2'b10) begin
            errors++;
            $display("FAIL back_to_idle: got exu_ready=%b wbu_valid=%b want 1,0", is_req_ready_to_exu, is_req_valid_to_wbu);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({is_req_ready_to_exu, mem_req_valid, mem_resp_ready, is_req_valid_to_wbu, reg_write_out_lsu,
             lsu_fault_out, is_data_forward_valid_from_lsu, mem_wen} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b%b%b%b%b%b%b%b want 10000000", is_req_ready_to_exu, mem_req_valid,
                     mem_resp_ready, is_req_valid_to_wbu, reg_write_out_lsu, lsu_fault_out,
                     is_data_forward_valid_from_lsu, mem_wen);
        end
        checks++;
        if ({wb_data_out_lsu, rd_out_lsu, mem_addr, mem_wdata, mem_wmask} !== '0) begin
            errors++;
            $display("FAIL reset_data: got wb=%h rd=%0d a=%h d=%h m=%b want all 0", wb_data_out_lsu,
                     rd_out_lsu, mem_addr, mem_wdata, mem_wmask);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_alu_passthrough;
        wb_q.push_back('{data: 32'h0000_1234, rd: 5'd5, rw: 1'b1, fault: 1'b0});
        run_txn(NO_MEM_READ, NO_MEM_WRITE, 32'h0000_1234, 32'h0, 32'h0, 1'b0, 0, 0, 5'd5, 1'b1, 1'b0);
    endtask

    task automatic test_load_extend;
        req_q.push_back('{addr: 32'h8000_0000, wen: 1'b0, wdata: 32'h0, wmask: 4'b0000});
        wb_q.push_back('{data: 32'hFFFF_FF80, rd: 5'd7, rw: 1'b1, fault: 1'b0});
        run_txn(LSU_LB, NO_MEM_WRITE, 32'h8000_0003, 32'h0, 32'h80FF_FFFF, 1'b0, 0, 0, 5'd7, 1'b1, 1'b1);
        req_q.push_back('{addr: 32'h8000_0000, wen: 1'b0, wdata: 32'h0, wmask: 4'b0000});
        wb_q.push_back('{data: 32'h0000_0080, rd: 5'd8, rw: 1'b1, fault: 1'b0});
        run_txn(LSU_LBU, NO_MEM_WRITE, 32'h8000_0003, 32'h0, 32'h80FF_FFFF, 1'b0, 0, 0, 5'd8, 1'b1, 1'b1);
        req_q.push_back('{addr: 32'h8000_0004, wen: 1'b0, wdata: 32'h0, wmask: 4'b0000});
        wb_q.push_back('{data: 32'hFFFF_9876, rd: 5'd9, rw: 1'b1, fault: 1'b0});
        run_txn(LSU_LH, NO_MEM_WRITE, 32'h8000_0006, 32'h0, 32'h9876_0011, 1'b0, 0, 0, 5'd9, 1'b1, 1'b1);
    endtask

    task automatic test_store_sh;
        req_q.push_back('{addr: 32'h8000_0000, wen: 1'b1, wdata: 32'hABCD_ABCD, wmask: 4'b1100});
        wb_q.push_back('{data: 32'h8000_0002, rd: 5'd3, rw: 1'b0, fault: 1'b0});
        run_txn(NO_MEM_READ, LSU_SH, 32'h8000_0002, 32'h0000_ABCD, 32'h0, 1'b0, 0, 0, 5'd3, 1'b1, 1'b1);
    endtask

    task automatic test_stall;
        req_q.push_back('{addr: 32'h8000_0100, wen: 1'b1, wdata: 32'hDEAD_BEEF, wmask: 4'b1111});
        wb_q.push_back('{data: 32'h8000_0100, rd: 5'd4, rw: 1'b0, fault: 1'b0});
        run_txn(NO_MEM_READ, LSU_SW, 32'h8000_0100, 32'hDEAD_BEEF, 32'h0, 1'b0, 5, 3, 5'd4, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({mem_req_valid, is_req_valid_to_wbu} !== 2'b00) begin
                errors++;
                $display("FAIL single_txn[%0d]: got req=%b wbu=%b want 0,0", i, mem_req_valid, is_req_valid_to_wbu);
            end
        end
    endtask

    task automatic test_fault;
        req_q.push_back('{addr: 32'h8000_0200, wen: 1'b1, wdata: 32'h1111_2222, wmask: 4'b1111});
        wb_q.push_back('{data: 32'h8000_0200, rd: 5'd6, rw: 1'b0, fault: 1'b1});
        run_txn(NO_MEM_READ, LSU_SW, 32'h8000_0200, 32'h1111_2222, 32'h0, 1'b1, 0, 0, 5'd6, 1'b1, 1'b1);
        req_q.push_back('{addr: 32'h8000_0204, wen: 1'b0, wdata: 32'h0, wmask: 4'b0000});
        wb_q.push_back('{data: 32'h5555_AAAA, rd: 5'd10, rw: 1'b0, fault: 1'b1});
        run_txn(LSU_LW, NO_MEM_WRITE, 32'h8000_0204, 32'h0, 32'h5555_AAAA, 1'b1, 0, 0, 5'd10, 1'b1, 1'b1);
`ifdef YSYX_25040129_LSU_MISALIGN_CHECK_EN
        wb_q.push_back('{data: 32'h8000_0001, rd: 5'd11, rw: 1'b0, fault: 1'b1});
        run_txn(LSU_LW, NO_MEM_WRITE, 32'h8000_0001, 32'h0, 32'h0, 1'b0, 0, 0, 5'd11, 1'b1, 1'b0);
`else
        req_q.push_back('{addr: 32'h8000_0000, wen: 1'b0, wdata: 32'h0, wmask: 4'b0000});
        wb_q.push_back('{data: 32'h1122_3344, rd: 5'd11, rw: 1'b1, fault: 1'b0});
        run_txn(LSU_LW, NO_MEM_WRITE, 32'h8000_0001, 32'h0, 32'h1122_3344, 1'b0, 0, 0, 5'd11, 1'b1, 1'b1);
`endif
    endtask

    task automatic test_reset_mid_resp;
        int n;
        @(negedge clk);
        is_req_valid_from_exu = 1'b1;
        result_in_lsu         = 32'h8000_0010;
        lsu_read_in_lsu       = LSU_LW;
        lsu_write_in_lsu      = NO_MEM_WRITE;
        rd_in_lsu             = 5'd12;
        reg_write_in_lsu      = 1'b1;
        @(negedge clk);
        is_req_valid_from_exu = 1'b0;
        mem_req_ready         = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        checks++;
        if (mem_resp_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_resp_state: got resp_ready=%b want 1", mem_resp_ready);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({is_req_ready_to_exu, mem_resp_ready, mem_req_valid, is_req_valid_to_wbu} !== 4'b1000) begin
            errors++;
            $display("FAIL mid_reset: got exu=%b resp=%b req=%b wbu=%b want 1,0,0,0", is_req_ready_to_exu,
                     mem_resp_ready, mem_req_valid, is_req_valid_to_wbu);
        end
        @(negedge clk);
        rst_n          = 1'b1;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'hCAFE_F00D;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (is_req_valid_to_wbu !== 1'b0 || is_req_ready_to_exu !== 1'b1) n++;
            @(negedge clk);
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL late_resp_ignored: got %0d bad cycles want 0", n);
        end
    endtask

    task automatic test_back_to_back;
        logic [2:0]  rt;
        logic [1:0]  wt;
        logic [31:0] addr, wd, rdata;
        logic [4:0]  rd;
        logic        rw;
        int          op;
        for (int k = 0; k < 16; k++) begin
            op    = $urandom_range(0, 8);
            rt    = NO_MEM_READ;
            wt    = NO_MEM_WRITE;
            wd    = $urandom;
            rdata = $urandom;
            rd    = 5'($urandom_range(1, 31));
            rw    = 1'($urandom_range(0, 1));
            addr  = 32'h8000_0000 | ($urandom & 32'h0000_FFFC);
            case (op)
                1: rt = LSU_LB;
                2: rt = LSU_LH;
                3: rt = LSU_LW;
                4: rt = LSU_LBU;
                5: rt = LSU_LHU;
                6: wt = LSU_SB;
                7: wt = LSU_SH;
                8: wt = LSU_SW;
                default: addr = $urandom;
            endcase
            if (rt == LSU_LB || rt == LSU_LBU || wt == LSU_SB) addr[1:0] = 2'($urandom_range(0, 3));
            if (rt == LSU_LH || rt == LSU_LHU || wt == LSU_SH) addr[1] = 1'($urandom_range(0, 1));
            if (op != 0) req_q.push_back(model_req(wt, addr, wd));
            wb_q.push_back('{data: (rt != NO_MEM_READ) ? model_load(rt, addr[1:0], rdata) : addr,
                             rd: rd, rw: rw && (wt == NO_MEM_WRITE), fault: 1'b0});
            run_txn(rt, wt, addr, wd, rdata, 1'b0, $urandom_range(0, 3), $urandom_range(0, 2),
                    rd, rw, op != 0);
        end
    endtask

    initial begin
        test_reset();
        test_alu_passthrough();
        test_load_extend();
        test_store_sh();
        test_stall();
        test_fault();
        test_reset_mid_resp();
        test_alu_passthrough();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
